// File: rtl/cpu_reg_transfer_if.sv
// rtl/cpu_reg_transfer_if.sv - command handshake and register-file bus bundle for cpu_reg_transfer
interface cpu_reg_transfer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [SEL_W-1:0] req_src;
  logic [SEL_W-1:0] req_dst;
  logic [WIDTH-1:0] req_imm;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [SEL_W-1:0] rf_sel;
  logic             rf_we;
  logic             rf_oe;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic             bus_drive;

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_imm, bus_in,
    output req_ready, done, err, result, rf_sel, rf_we, rf_oe, bus_out, bus_drive
  );

  modport master (
    output req_valid, req_op, req_src, req_dst, req_imm, bus_in,
    input  req_ready, done, err, result, rf_sel, rf_we, rf_oe, bus_out, bus_drive
  );
endinterface

// File: rtl/cpu_reg_transfer.sv
// rtl/cpu_reg_transfer.sv - register-file transfer sequencer (MOV/LDI/RD; SWAP when REG_XFER_SWAP_EN is defined)
module cpu_reg_transfer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  cpu_reg_transfer_if.slave  xfer
);
  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
`ifdef REG_XFER_SWAP_EN
  localparam logic [1:0] OP_SWAP = 2'b11;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_A  = 3'd1,
    READ_B  = 3'd2,
    WRITE_A = 3'd3,
    WRITE_B = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       op_q;
  logic [SEL_W-1:0] src_q, dst_q;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [WIDTH-1:0] tmp0, result_q;
`ifdef REG_XFER_SWAP_EN
  logic [WIDTH-1:0] tmp1;
`endif
  logic             accept;

  assign accept = (state == IDLE) && xfer.req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      sel_q    <= '0;
      tmp0     <= '0;
      result_q <= '0;
`ifdef REG_XFER_SWAP_EN
      tmp1     <= '0;
`endif
    end else begin
      state <= state_nx;
      sel_q <= sel_nx;
      if (accept) begin
        op_q  <= xfer.req_op;
        src_q <= xfer.req_src;
        dst_q <= xfer.req_dst;
        if (xfer.req_op == OP_LDI)
          tmp0 <= xfer.req_imm;
      end
      // READ_A feeds either the RD result or the first transfer temp
      if (state == READ_A) begin
        if (op_q == OP_RD)
          result_q <= xfer.bus_in;
        else
          tmp0 <= xfer.bus_in;
      end
`ifdef REG_XFER_SWAP_EN
      if (state == READ_B)
        tmp1 <= xfer.bus_in;
`endif
    end
  end

  // sel is loaded together with the state it belongs to, so it holds outside READ/WRITE
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    unique case (state)
      IDLE: begin
        if (xfer.req_valid) begin
          unique case (xfer.req_op)
            OP_MOV, OP_RD: begin state_nx = READ_A;  sel_nx = xfer.req_src; end
            OP_LDI:        begin state_nx = WRITE_A; sel_nx = xfer.req_dst; end
`ifdef REG_XFER_SWAP_EN
            OP_SWAP:       begin state_nx = READ_A;  sel_nx = xfer.req_src; end
`endif
            default:       state_nx = DONE;
          endcase
        end
      end
      READ_A: begin
        if (op_q == OP_RD) begin
          state_nx = DONE;
`ifdef REG_XFER_SWAP_EN
        end else if (op_q == OP_SWAP) begin
          state_nx = READ_B;
          sel_nx   = dst_q;
`endif
        end else begin
          state_nx = WRITE_A;
          sel_nx   = dst_q;
        end
      end
`ifdef REG_XFER_SWAP_EN
      READ_B: begin state_nx = WRITE_A; sel_nx = dst_q; end
      WRITE_A: begin
        if (op_q == OP_SWAP) begin
          state_nx = WRITE_B;
          sel_nx   = src_q;
        end else begin
          state_nx = DONE;
        end
      end
      WRITE_B: state_nx = DONE;
`else
      WRITE_A: state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign xfer.req_ready = (state == IDLE);
  assign xfer.done      = (state == DONE);
  assign xfer.rf_sel    = sel_q;
  assign xfer.result    = result_q;
  assign xfer.rf_oe     = (state == READ_A) || (state == READ_B);
  assign xfer.rf_we     = (state == WRITE_A) || (state == WRITE_B);
  assign xfer.bus_drive = xfer.rf_we;
`ifdef REG_XFER_SWAP_EN
  assign xfer.err       = 1'b0;
  assign xfer.bus_out   = (state == WRITE_A) ? tmp0 : (state == WRITE_B) ? tmp1 : '0;
`else
  assign xfer.err       = (state == DONE) && (op_q == 2'b11);
  assign xfer.bus_out   = (state == WRITE_A) ? tmp0 : '0;
`endif
endmodule
